// File: rtl/pythag_leg_solver.sv
// Inverse-Pythagoras unit: leg = floor(sqrt(h*h - a*a)), found by an 8-step bit-serial root search.
// Outputs are registered, so the FINISH cycle commits them and they are visible in the cycle after it.
module pythag_leg_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] h,
  input  logic [7:0] a,
  output logic       busy,
  output logic       done,
  output logic [7:0] leg,
  output logic       invalid
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned SQ_W   = 16;
  localparam int unsigned DIFF_W = 17;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SQ_W-1:0]   diff, diff_nxt;
  logic [OP_W-1:0]   root, root_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              flag, flag_nxt;
  logic              busy_nxt, done_nxt, invalid_nxt;
  logic [OP_W-1:0]   leg_nxt;

  logic [SQ_W-1:0]   h_sq_c, a_sq_c, trial_sq_c;
  logic [DIFF_W-1:0] diff_c;
  logic [OP_W-1:0]   trial_c;

  // Squares and signed difference of the live operands; only used on the accepting edge.
  always_comb begin
    h_sq_c     = SQ_W'(h) * SQ_W'(h);
    a_sq_c     = SQ_W'(a) * SQ_W'(a);
    diff_c     = DIFF_W'(h_sq_c) - DIFF_W'(a_sq_c);
    trial_c    = root | (OP_W'(1) << idx);
    trial_sq_c = SQ_W'(trial_c) * SQ_W'(trial_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      diff    <= '0;
      root    <= '0;
      idx     <= '0;
      flag    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      leg     <= '0;
      invalid <= 1'b0;
    end else begin
      state   <= state_nxt;
      diff    <= diff_nxt;
      root    <= root_nxt;
      idx     <= idx_nxt;
      flag    <= flag_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      leg     <= leg_nxt;
      invalid <= invalid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    diff_nxt    = diff;
    root_nxt    = root;
    idx_nxt     = idx;
    flag_nxt    = flag;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    leg_nxt     = leg;
    invalid_nxt = invalid;

    unique case (state)
      IDLE: begin
        if (start) begin
          diff_nxt = diff_c[SQ_W-1:0];
          root_nxt = '0;
          idx_nxt  = IDX_W'(OP_W - 1);
          // A negative difference means a > h: skip the search entirely.
          if (diff_c[DIFF_W-1]) begin
            flag_nxt  = 1'b1;
            state_nxt = FINISH;
          end else begin
            flag_nxt  = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = SEARCH;
          end
        end
      end

      SEARCH: begin
        if (trial_sq_c <= diff) root_nxt = trial_c;
        if (idx == '0) state_nxt = FINISH;
        else           idx_nxt   = idx - IDX_W'(1);
      end

      FINISH: begin
        leg_nxt     = flag ? '0 : root;
        invalid_nxt = flag;
        done_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Directed and randomized bench for pythag_leg_solver against an arithmetic reference model.
module tb_pythag_leg_solver;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] h;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic [7:0] leg;
  logic       invalid;

  int checks = 0;
  int errors = 0;

  pythag_leg_solver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .h       (h),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .leg     (leg),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Largest r with r*r <= h*h - a*a, or 0 when a > h.
  function automatic int model_leg(input int hv, input int av);
    int d, r;
    if (av > hv) return 0;
    d = hv * hv - av * av;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; counts edges until done and busy-high samples before it.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    if (busy === 1'b1) bcnt++;
    while (done !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic req(input logic [7:0] hv, input logic [7:0] av, input string tag);
    int lat, bc, exp_leg;
    bit exp_inv;
    exp_inv = (av > hv);
    exp_leg = model_leg(int'(hv), int'(av));
    @(negedge clk);
    h = hv; a = av; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    h = 8'($urandom);
    a = 8'($urandom);
    wait_done(lat, bc);
    chk({tag, "_latency"}, 32'(lat), exp_inv ? 32'd1 : 32'd9);
    chk({tag, "_busy_cycles"}, 32'(bc), exp_inv ? 32'd0 : 32'd9);
    chk({tag, "_leg"}, 32'(leg), 32'(exp_leg));
    chk({tag, "_invalid"}, 32'(invalid), 32'(exp_inv));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_leg_hold"}, 32'(leg), 32'(exp_leg));
  endtask

  initial begin
    int lat, bc;
    logic [7:0] rh, ra;
    rst_n = 1'b0; start = 1'b0; h = '0; a = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_leg", 32'(leg), 32'd0);
    chk("reset_invalid", 32'(invalid), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    req(8'd5, 8'd3, "triple_5_3");
    req(8'd255, 8'd0, "h255_a0");
    req(8'd200, 8'd120, "h200_a120");
    req(8'd10, 8'd7, "h10_a7");
    req(8'd3, 8'd5, "invalid_3_5");
    req(8'd5, 8'd4, "after_invalid_5_4");
    req(8'd77, 8'd77, "h_eq_a");
    req(8'd0, 8'd0, "zero_zero");
    req(8'd255, 8'd255, "max_eq");
    req(8'd0, 8'd1, "invalid_0_1");

    // Start held high: inputs change mid-search and the second request waits for the done cycle.
    @(negedge clk);
    h = 8'd13; a = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy_after_accept", 32'(busy), 32'd1);
    h = 8'd100; a = 8'd99;
    wait_done(lat, bc);
    chk("hold_first_latency", 32'(lat), 32'd9);
    chk("hold_first_leg", 32'(leg), 32'd12);
    chk("hold_first_invalid", 32'(invalid), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_done_single", 32'(done), 32'd0);
    chk("hold_second_busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    chk("hold_second_latency", 32'(lat), 32'd9);
    chk("hold_second_leg", 32'(leg), 32'd14);
    @(posedge clk); #1;
    chk("hold_second_done_single", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a search discards the request.
    @(negedge clk);
    h = 8'd20; a = 8'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_leg", 32'(leg), 32'd0);
    chk("midrst_invalid", 32'(invalid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    req(8'd17, 8'd8, "after_reset_17_8");

    // Output hold: random operands with start low must not disturb the last result.
    req(8'd5, 8'd3, "hold_setup_5_3");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      h = 8'($urandom); a = 8'($urandom);
      @(posedge clk); #1;
      chk("idle_leg", 32'(leg), 32'd4);
      chk("idle_invalid", 32'(invalid), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      rh = 8'($urandom);
      ra = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, int'(rh)));
      req(rh, ra, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
